// File: rtl/verification_sequencer.sv
// Write/verify sequencer: streams a loaded image into a target register file,
// optionally reads it back and counts mismatches against the image.
module verification_sequencer #(
  parameter int ADDRESS_SIZE = 6,
  parameter int DATA_SIZE    = 8,
  parameter int LOCATIONS    = 49,
  parameter int READ_LATENCY = 1,
  parameter int ERR_SIZE     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_load_en,
  input  logic [ADDRESS_SIZE-1:0] i_load_addr,
  input  logic [DATA_SIZE-1:0]    i_load_data,
  input  logic                    i_start,
  input  logic [1:0]              i_mode,
  input  logic                    i_abort,
  input  logic [DATA_SIZE-1:0]    i_rdata,
  output logic [ADDRESS_SIZE-1:0] o_address,
  output logic [DATA_SIZE-1:0]    o_data,
  output logic                    o_write_en,
  output logic                    o_read_en,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_aborted,
  output logic                    o_pass,
  output logic [ERR_SIZE-1:0]     o_error_count,
  output logic [ADDRESS_SIZE-1:0] o_first_error_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(LOCATIONS - 1);
  localparam logic [ADDRESS_SIZE:0]   LOC_LIMIT = (ADDRESS_SIZE + 1)'(LOCATIONS);

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic                    write_en_q, write_en_d;
  logic                    read_en_q, read_en_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    pass_q, pass_d;
  logic [ERR_SIZE-1:0]     err_q, err_d;
  logic [ADDRESS_SIZE-1:0] first_q, first_d;
  logic                    seen_q, seen_d;

  logic [DATA_SIZE-1:0]    image_mem [LOCATIONS];
  logic [ADDRESS_SIZE-1:0] rd_addr;
  logic [DATA_SIZE-1:0]    img_rd_q;

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [ADDRESS_SIZE-1:0] paddr_q [READ_LATENCY];
  logic [ADDRESS_SIZE-1:0] paddr_d [READ_LATENCY];
  logic [DATA_SIZE-1:0]    pexp_q  [READ_LATENCY];
  logic [DATA_SIZE-1:0]    pexp_d  [READ_LATENCY];

  logic flush;
  logic pending;
  logic mismatch;

  // Single read port feeds both the write data path and the expected-data pipeline.
  always_ff @(posedge i_clk) begin
    if (i_load_en && !busy_q && ({1'b0, i_load_addr} < LOC_LIMIT)) begin
      image_mem[i_load_addr] <= i_load_data;
    end
    img_rd_q <= image_mem[rd_addr];
  end

  assign flush = i_abort && busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign vld_d[gi]   = read_en_q && !flush;
        assign paddr_d[gi] = addr_q;
        assign pexp_d[gi]  = img_rd_q;
      end else begin : g_tail
        assign vld_d[gi]   = vld_q[gi-1] && !flush;
        assign paddr_d[gi] = paddr_q[gi-1];
        assign pexp_d[gi]  = pexp_q[gi-1];
      end
    end
    if (READ_LATENCY > 1) begin : g_pend
      assign pending = |vld_q[READ_LATENCY-2:0];
    end else begin : g_nopend
      assign pending = 1'b0;
    end
  endgenerate

  assign mismatch = vld_q[READ_LATENCY-1] && !flush &&
                    (i_rdata != pexp_q[READ_LATENCY-1]);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    write_en_d = 1'b0;
    read_en_d  = 1'b0;
    addr_d     = '0;
    rd_addr    = '0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    first_d    = first_q;
    seen_d     = seen_q;

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (!seen_q) begin
        seen_d  = 1'b1;
        first_d = paddr_q[READ_LATENCY-1];
      end
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          mode_d  = i_mode;
          pass_d  = 1'b0;
          err_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
          if (i_mode == 2'b10) begin
            state_d   = READ;
            read_en_d = 1'b1;
          end else begin
            state_d    = WRITE;
            write_en_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (i_abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          if (mode_q == 2'b01) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d   = READ;
            read_en_d = 1'b1;
          end
        end else begin
          write_en_d = 1'b1;
          addr_d     = addr_q + 1'b1;
          rd_addr    = addr_q + 1'b1;
        end
      end
      READ: begin
        if (i_abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          read_en_d = 1'b1;
          addr_d    = addr_q + 1'b1;
          rd_addr   = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Leave once only the final stage remains; its compare lands this cycle.
        if (i_abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (!pending) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      first_q    <= '0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      write_en_q <= write_en_d;
      read_en_q  <= read_en_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      first_q    <= first_d;
      seen_q     <= seen_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        paddr_q[i] <= '0;
        pexp_q[i]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        paddr_q[i] <= paddr_d[i];
        pexp_q[i]  <= pexp_d[i];
      end
    end
  end

  assign o_address          = addr_q;
  assign o_data             = write_en_q ? img_rd_q : '0;
  assign o_write_en         = write_en_q;
  assign o_read_en          = read_en_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_aborted          = aborted_q;
  assign o_pass             = pass_q;
  assign o_error_count      = err_q;
  assign o_first_error_addr = first_q;

endmodule

// File: tb/tb_verification_sequencer.sv
// Bench for verification_sequencer: echoing target models, a write/read
// scoreboard on the default instance, and a latency-4 / 4-bit-counter instance.
module tb_verification_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_en = 1'b0;
  logic [5:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic abort = 1'b0;

  logic [7:0] rdata1 = '0, rdata4 = '0;
  logic [5:0] addr1, addr4, first1, first4;
  logic [7:0] data1, data4, err1;
  logic [3:0] err4;
  logic we1, re1, busy1, done1, abt1, pass1;
  logic we4, re4, busy4, done4, abt4, pass4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [5:0] a; logic [7:0] d;} wr_t;
  wr_t        exp_wr [$];
  logic [5:0] exp_rd [$];
  int         wr_seen = 0;
  int         rd_seen = 0;

  logic [7:0] img  [64];
  logic [7:0] mem1 [64];
  logic [7:0] mem4 [64];
  bit         corrupt [64];
  bit         p1_v [2];
  logic [5:0] p1_a [2];
  bit         p4_v [5];
  logic [5:0] p4_a [5];

  always #5 clk = ~clk;

  verification_sequencer dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_load_en(load_en), .i_load_addr(load_addr),
    .i_load_data(load_data), .i_start(start), .i_mode(mode), .i_abort(abort),
    .i_rdata(rdata1), .o_address(addr1), .o_data(data1), .o_write_en(we1),
    .o_read_en(re1), .o_busy(busy1), .o_done(done1), .o_aborted(abt1),
    .o_pass(pass1), .o_error_count(err1), .o_first_error_addr(first1)
  );

  verification_sequencer #(.READ_LATENCY(4), .ERR_SIZE(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_load_en(load_en), .i_load_addr(load_addr),
    .i_load_data(load_data), .i_start(start), .i_mode(mode), .i_abort(abort),
    .i_rdata(rdata4), .o_address(addr4), .o_data(data4), .o_write_en(we4),
    .o_read_en(re4), .o_busy(busy4), .o_done(done4), .o_aborted(abt4),
    .o_pass(pass4), .o_error_count(err4), .o_first_error_addr(first4)
  );

  // Target models: store writes, return stored data READ_LATENCY cycles after a read.
  always @(negedge clk) begin
    if (we1) mem1[addr1] = data1;
    p1_v[1] = p1_v[0]; p1_a[1] = p1_a[0];
    p1_v[0] = re1;     p1_a[0] = addr1;
    rdata1 = p1_v[1] ? (mem1[p1_a[1]] ^ (corrupt[p1_a[1]] ? 8'h5A : 8'h00)) : 8'h00;
  end

  always @(negedge clk) begin
    if (we4) mem4[addr4] = data4;
    for (int i = 4; i > 0; i--) begin
      p4_v[i] = p4_v[i-1];
      p4_a[i] = p4_a[i-1];
    end
    p4_v[0] = re4; p4_a[0] = addr4;
    rdata4 = p4_v[4] ? (mem4[p4_a[4]] ^ (corrupt[p4_a[4]] ? 8'h5A : 8'h00)) : 8'h00;
  end

  // Scoreboard monitor on the default instance.
  always @(negedge clk) begin
    wr_t e;
    logic [5:0] ea;
    if (rst_n) begin
      if (we1 && re1) begin
        checks++; errors++;
        $display("FAIL both_strobes at %0t: write_en=1 read_en=1, required not both", $time);
      end
      if (we1) begin
        checks++; wr_seen++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%0h, required no write", addr1, data1);
        end else begin
          e = exp_wr.pop_front();
          if ({addr1, data1} !== {e.a, e.d}) begin
            errors++;
            $display("FAIL write_txn got addr=%0d data=%0h, required addr=%0d data=%0h",
                     addr1, data1, e.a, e.d);
          end
        end
      end
      if (re1) begin
        checks++; rd_seen++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read addr=%0d, required no read", addr1);
        end else begin
          ea = exp_rd.pop_front();
          if (addr1 !== ea) begin
            errors++;
            $display("FAIL read_txn got addr=%0d, required addr=%0d", addr1, ea);
          end
        end
      end
      if (!we1 && !re1) begin
        checks++;
        if (addr1 !== 6'd0 || data1 !== 8'd0) begin
          errors++;
          $display("FAIL idle_bus got addr=%0d data=%0h, required 0/0", addr1, data1);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({addr1, data1, we1, re1, busy1, done1, abt1, pass1, err1, first1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h, required 0",
               {addr1, data1, we1, re1, busy1, done1, abt1, pass1, err1, first1});
    end
    checks++;
    if ({addr4, data4, we4, re4, busy4, done4, abt4, pass4, err4, first4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_l4 got %0h, required 0",
               {addr4, data4, we4, re4, busy4, done4, abt4, pass4, err4, first4});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, we1, re1, done1} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy/we/re/done=%b, required 0000", {busy1, we1, re1, done1});
    end
    $display("txn reset: released");
  endtask

  task automatic load_image();
    for (int k = 0; k < 49; k++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = 6'(k); load_data = 8'(k + 1);
      img[k] = 8'(k + 1);
    end
    @(negedge clk);
    load_addr = 6'd55; load_data = 8'hFF;
    @(negedge clk);
    load_en = 1'b0;
    $display("txn load: image[k]=k+1 for 49 words");
  endtask

  task automatic run_seq(input string name, input logic [1:0] m, input int nwr, input int nrd,
                         input logic xp, input logic [7:0] xerr, input logic [5:0] xfirst,
                         input logic xp4, input logic [3:0] xerr4, input logic [5:0] xfirst4);
    int cyc, cyc_done, ndone;
    bit got1, got4;
    logic cp, cp4;
    logic [7:0] ce;
    logic [3:0] ce4;
    logic [5:0] cf, cf4;
    exp_wr.delete(); exp_rd.delete();
    for (int k = 0; k < nwr; k++) exp_wr.push_back({6'(k), img[k]});
    for (int k = 0; k < nrd; k++) exp_rd.push_back(6'(k));
    wr_seen = 0; rd_seen = 0;
    cyc = 0; cyc_done = 0; ndone = 0; got1 = 0; got4 = 0;
    cp = 0; cp4 = 0; ce = 0; ce4 = 0; cf = 0; cf4 = 0;
    @(negedge clk);
    start = 1'b1; mode = m;
    while ((!got1 || !got4) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done1) ndone++;
      if (abt1) begin
        checks++; errors++;
        $display("FAIL %s_aborted unexpected abort pulse, required none", name);
      end
      if (done1 && !got1) begin got1 = 1; cyc_done = cyc; cp = pass1; ce = err1; cf = first1; end
      if (done4 && !got4) begin got4 = 1; cp4 = pass4; ce4 = err4; cf4 = first4; end
    end
    @(negedge clk);
    if (done1) ndone++;
    checks++;
    if (!got1 || !got4) begin
      errors++;
      $display("FAIL %s_timeout done=%b done_l4=%b, required 11", name, got1, got4);
    end
    checks++;
    if (cyc_done != 1 + nwr + nrd + ((nrd > 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_latency got %0d cycles, required %0d", name, cyc_done,
               1 + nwr + nrd + ((nrd > 0) ? 1 : 0));
    end
    checks++;
    if ({cp, ce, cf} !== {xp, xerr, xfirst}) begin
      errors++;
      $display("FAIL %s_result got pass=%b err=%0d first=%0d, required pass=%b err=%0d first=%0d",
               name, cp, ce, cf, xp, xerr, xfirst);
    end
    checks++;
    if ({cp4, ce4, cf4} !== {xp4, xerr4, xfirst4}) begin
      errors++;
      $display("FAIL %s_result_l4 got pass=%b err=%0d first=%0d, required pass=%b err=%0d first=%0d",
               name, cp4, ce4, cf4, xp4, xerr4, xfirst4);
    end
    checks++;
    if (wr_seen != nwr || rd_seen != nrd || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL %s_counts got writes=%0d reads=%0d, required writes=%0d reads=%0d",
               name, wr_seen, rd_seen, nwr, nrd);
    end
    checks++;
    if (ndone != 1 || busy1 !== 1'b0 || pass1 !== xp) begin
      errors++;
      $display("FAIL %s_after_done got done_cycles=%0d busy=%b pass=%b, required 1/0/%b",
               name, ndone, busy1, pass1, xp);
    end
    $display("txn %s: mode=%b writes=%0d reads=%0d cycles=%0d pass=%b err=%0d first=%0d | l4 pass=%b err=%0d",
             name, m, wr_seen, rd_seen, cyc_done, cp, ce, cf, cp4, ce4);
    exp_wr.delete(); exp_rd.delete();
  endtask

  task automatic test_write_verify();
    run_seq("write_verify", 2'b00, 49, 49, 1'b1, 8'd0, 6'd0, 1'b1, 4'd0, 6'd0);
    run_seq("reserved_mode", 2'b11, 49, 49, 1'b1, 8'd0, 6'd0, 1'b1, 4'd0, 6'd0);
  endtask

  task automatic test_corrupt();
    corrupt[5] = 1; corrupt[30] = 1;
    run_seq("corrupt_5_30", 2'b00, 49, 49, 1'b0, 8'd2, 6'd5, 1'b0, 4'd2, 6'd5);
    corrupt[5] = 0; corrupt[30] = 0;
  endtask

  task automatic test_modes();
    run_seq("write_only", 2'b01, 49, 0, 1'b1, 8'd0, 6'd0, 1'b1, 4'd0, 6'd0);
    run_seq("verify_only", 2'b10, 0, 49, 1'b1, 8'd0, 6'd0, 1'b1, 4'd0, 6'd0);
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 64; k++) corrupt[k] = 1;
    run_seq("all_mismatch", 2'b10, 0, 49, 1'b0, 8'd49, 6'd0, 1'b0, 4'd15, 6'd0);
    for (int k = 0; k < 64; k++) corrupt[k] = 0;
    run_seq("after_saturate", 2'b10, 0, 49, 1'b1, 8'd0, 6'd0, 1'b1, 4'd0, 6'd0);
  endtask

  task automatic test_abort();
    bit hit;
    int ndone;
    exp_wr.delete(); exp_rd.delete();
    for (int k = 0; k < 49; k++) exp_wr.push_back({6'(k), img[k]});
    wr_seen = 0; rd_seen = 0; hit = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'b00;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0; load_en = 1'b0;
      if (we1 && addr1 == 6'd10) begin
        start = 1'b1; mode = 2'b10;
        load_en = 1'b1; load_addr = 6'd3; load_data = 8'hEE;
      end
      if (we1 && addr1 == 6'd20) begin
        abort = 1'b1; hit = 1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!hit || {abt1, busy1, done1, we1, pass1, abt4, busy4} !== 7'b1000010) begin
      errors++;
      $display("FAIL abort_pulse got hit=%b aborted/busy/done/we/pass/aborted_l4/busy_l4=%b, required 1000010",
               hit, {abt1, busy1, done1, we1, pass1, abt4, busy4});
    end
    checks++;
    if (wr_seen != 21 || rd_seen != 0) begin
      errors++;
      $display("FAIL abort_writes got writes=%0d reads=%0d, required 21/0", wr_seen, rd_seen);
    end
    exp_wr.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done1 || abt1 || busy1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles after abort, required 0", ndone);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (abt1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got aborted=%b, required 0", abt1);
    end
    $display("txn abort: writes=%0d before abort", wr_seen);
    run_seq("post_abort_verify", 2'b10, 0, 49, 1'b1, 8'd0, 6'd0, 1'b1, 4'd0, 6'd0);
  endtask

  task automatic test_reset_mid_read();
    bit hit;
    int nact;
    exp_wr.delete(); exp_rd.delete();
    for (int k = 0; k < 49; k++) exp_rd.push_back(6'(k));
    hit = 0; nact = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'b10;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (re1 && addr1 == 6'd10) hit = 1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!hit || {addr1, data1, we1, re1, busy1, done1, abt1, pass1, err1, first1} !== '0) begin
      errors++;
      $display("FAIL reset_mid_read got hit=%b outputs=%0h, required hit=1 outputs=0", hit,
               {addr1, data1, we1, re1, busy1, done1, abt1, pass1, err1, first1});
    end
    exp_rd.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy1 || we1 || re1 || done1) nact++;
    end
    checks++;
    if (nact != 0) begin
      errors++;
      $display("FAIL reset_no_restart got %0d active cycles, required 0", nact);
    end
    $display("txn reset_mid_read: reset at read 10");
    run_seq("post_reset_verify", 2'b10, 0, 49, 1'b1, 8'd0, 6'd0, 1'b1, 4'd0, 6'd0);
  endtask

  initial begin
    test_reset();
    load_image();
    test_write_verify();
    test_corrupt();
    test_modes();
    test_saturate();
    test_abort();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
